// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port unified memory of the 8-bit CPU.
// Arbitrates between the debug, data and fetch ports and tags each read response.
module mem_port_arbiter #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {OwnNone, OwnDbg, OwnD, OwnIf} owner_e;

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       fetch_pri;

  assign fetch_pri = (starve_q == Limit);

  // Grants are gated by rstn so the memory port stays quiet during reset.
  always_comb begin
    dbg_gnt = 1'b0;
    d_gnt   = 1'b0;
    if_gnt  = 1'b0;
    if (rstn) begin
      if (dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (if_req && (fetch_pri || !d_req)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OwnNone;
    if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      if (!dbg_we) owner_d = OwnDbg;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      if (!d_we) owner_d = OwnD;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      owner_d  = OwnIf;
    end
  end

  // Debug grants with a waiting fetch fall through and hold the count.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != Limit)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      owner_q  <= OwnNone;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign dbg_rvalid = (owner_q == OwnDbg);
  assign d_rvalid   = (owner_q == OwnD);
  assign if_rvalid  = (owner_q == OwnIf);
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       d_req, d_we, d_gnt, d_rvalid;
  logic [7:0] d_addr, d_wdata;
  logic       if_req, if_gnt, if_rvalid;
  logic [7:0] if_addr;
  logic [7:0] rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  logic [7:0] mem [256];
  logic       preloaded = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous single-port memory; a read returns the pre-write contents.
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem[8'h10] <= 8'h7C;
      mem[8'h20] <= 8'h44;
      mem[8'h30] <= 8'h11;
      preloaded  <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req = 1'b0; if_addr = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    dbg_req = 1'b1; dbg_addr = 8'h10; d_req = 1'b1; d_addr = 8'h20;
    if_req = 1'b1; if_addr = 8'h00;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({dbg_gnt, d_gnt, if_gnt, mem_en} !== 4'b0000)
      $display("FAIL reset_gnt: got gnt/en %b want 0000", {dbg_gnt, d_gnt, if_gnt, mem_en});
    else passed++;
    checks++;
    if ({dbg_rvalid, d_rvalid, if_rvalid} !== 3'b000)
      $display("FAIL reset_rvalid: got %b want 000", {dbg_rvalid, d_rvalid, if_rvalid});
    else passed++;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({dbg_gnt, d_gnt, if_gnt, mem_en, mem_addr} !== {4'b1001, 8'h10})
      $display("FAIL release_dbg_gnt: got %b addr %h want 1001 addr 10",
               {dbg_gnt, d_gnt, if_gnt, mem_en}, mem_addr);
    else passed++;
    tick();
    idle_reqs();
    @(negedge clk);
    checks++;
    if ({dbg_rvalid, d_rvalid, if_rvalid, rdata} !== {3'b100, 8'h7C})
      $display("FAIL release_dbg_read: got rv %b data %h want 100 data 7c",
               {dbg_rvalid, d_rvalid, if_rvalid}, rdata);
    else passed++;
  endtask

  task automatic test_single_fetch();
    tick();
    if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk);
    checks++;
    if ({if_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 8'h10})
      $display("FAIL fetch_gnt: got gnt/en/we %b addr %h want 110 addr 10",
               {if_gnt, mem_en, mem_we}, mem_addr);
    else passed++;
    tick();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({dbg_rvalid, d_rvalid, if_rvalid, rdata} !== {3'b001, 8'h7C})
      $display("FAIL fetch_resp: got rv %b data %h want 001 data 7c",
               {dbg_rvalid, d_rvalid, if_rvalid}, rdata);
    else passed++;
    checks++;
    if ({if_gnt, mem_en} !== 2'b00)
      $display("FAIL fetch_idle: got gnt/en %b want 00", {if_gnt, mem_en});
    else passed++;
  endtask

  task automatic test_contention();
    logic [9:0] exp_if;
    exp_if = 10'b1000010000;  // bit i set: fetch wins cycle i
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i < 10) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; if_req = 1'b1; if_addr = 8'h00;
      end else begin
        idle_reqs();
      end
      @(negedge clk);
      if (i < 10) begin
        checks++;
        if ({d_gnt, if_gnt} !== {~exp_if[i], exp_if[i]})
          $display("FAIL contention_gnt[%0d]: got d/if %b want %b", i, {d_gnt, if_gnt},
                   {~exp_if[i], exp_if[i]});
        else passed++;
      end
      if (i > 0) begin
        checks++;
        if ({d_rvalid, if_rvalid, rdata} !==
            {~exp_if[i-1], exp_if[i-1], exp_if[i-1] ? 8'h5A : 8'h44})
          $display("FAIL contention_resp[%0d]: got d/if rv %b data %h want %b data %h", i,
                   {d_rvalid, if_rvalid}, rdata, {~exp_if[i-1], exp_if[i-1]},
                   exp_if[i-1] ? 8'h5A : 8'h44);
        else passed++;
      end
    end
  endtask

  task automatic test_debug_load();
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h05; dbg_wdata = 8'hB2;
    if_req = 1'b1; if_addr = 8'h05;
    @(negedge clk);
    checks++;
    if ({dbg_gnt, if_gnt, mem_we, mem_addr, mem_wdata} !== {3'b101, 8'h05, 8'hB2})
      $display("FAIL dbg_write: got gnt/if/we %b addr %h wd %h want 101 addr 05 wd b2",
               {dbg_gnt, if_gnt, mem_we}, mem_addr, mem_wdata);
    else passed++;
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt, dbg_rvalid} !== 2'b10)
      $display("FAIL dbg_then_fetch: got if_gnt/dbg_rvalid %b want 10", {if_gnt, dbg_rvalid});
    else passed++;
    tick();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({dbg_rvalid, if_rvalid, rdata} !== {2'b01, 8'hB2})
      $display("FAIL dbg_load_fetch: got rv %b data %h want 01 data b2",
               {dbg_rvalid, if_rvalid}, rdata);
    else passed++;
  endtask

  task automatic test_back_to_back();
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
    @(negedge clk);
    checks++;
    if ({d_gnt, mem_we} !== 2'b10)
      $display("FAIL rw_read_gnt: got gnt/we %b want 10", {d_gnt, mem_we});
    else passed++;
    tick();
    d_we = 1'b1; d_wdata = 8'h99;
    @(negedge clk);
    checks++;
    if ({d_gnt, mem_we, d_rvalid, rdata} !== {3'b111, 8'h11})
      $display("FAIL rw_old_data: got gnt/we/rv %b data %h want 111 data 11",
               {d_gnt, mem_we, d_rvalid}, rdata);
    else passed++;
    tick();
    d_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_gnt, d_rvalid} !== 2'b10)
      $display("FAIL rw_write_no_rvalid: got gnt/rv %b want 10", {d_gnt, d_rvalid});
    else passed++;
    tick();
    idle_reqs();
    @(negedge clk);
    checks++;
    if ({d_rvalid, rdata} !== {1'b1, 8'h99})
      $display("FAIL rw_new_data: got rv %b data %h want 1 data 99", d_rvalid, rdata);
    else passed++;
  endtask

  task automatic test_reset_mid_read();
    tick();
    if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) $display("FAIL midrd_gnt: got %b want 1", if_gnt);
    else passed++;
    rstn = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_gnt} !== 2'b00)
      $display("FAIL midrd_dropped: got rv/gnt %b want 00", {if_rvalid, if_gnt});
    else passed++;
    tick();
    rstn = 1'b1;
    // Build the starvation count to 3, then reset; the count must restart at 0.
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; if_req = 1'b1; if_addr = 8'h00;
      @(negedge clk);
      checks++;
      if ({d_gnt, if_gnt} !== 2'b10)
        $display("FAIL midrd_pre[%0d]: got d/if %b want 10", i, {d_gnt, if_gnt});
      else passed++;
      if (i == 2) rstn = 1'b0;
      tick();
    end
    @(negedge clk);
    checks++;
    if ({dbg_gnt, d_gnt, if_gnt, d_rvalid} !== 4'b0000)
      $display("FAIL midrd_in_reset: got gnt/rv %b want 0000",
               {dbg_gnt, d_gnt, if_gnt, d_rvalid});
    else passed++;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({d_gnt, if_gnt} !== ((i == 4) ? 2'b01 : 2'b10))
        $display("FAIL starve_restart[%0d]: got d/if %b want %b", i, {d_gnt, if_gnt},
                 (i == 4) ? 2'b01 : 2'b10);
      else passed++;
      tick();
    end
    idle_reqs();
  endtask

  initial begin
    rstn = 1'b0;
    idle_reqs();
    test_reset();
    test_single_fetch();
    test_contention();
    test_debug_load();
    test_back_to_back();
    test_reset_mid_read();
    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the single-port unified instruction/data memory of the pipelined 8-bit CPU between three requesters: a debug/loader port, the MEM-stage data access and the IF-stage instruction fetch. Each cycle it grants at most one requester and drives that requester's request onto the memory port. It tags the one-cycle-latency read response back to the requester that issued the read. A starvation counter guarantees fetch progress when back-to-back data accesses would otherwise stall the front end indefinitely.

## Interface
- AW, 8, address width
- DW, 8, data width
- STARVE_LIMIT, 4, consecutive data grants that may overtake a waiting fetch (1..15)

- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- dbg_req  in  1  debug/loader access request
- dbg_we  in  1  debug write (1) / read (0)
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_gnt  out  1  debug granted this cycle
- dbg_rvalid  out  1  debug read data valid on rdata
- d_req  in  1  MEM-stage access request
- d_we  in  1  MEM-stage write (1) / read (0)
- d_addr  in  AW  MEM-stage address
- d_wdata  in  DW  MEM-stage write data
- d_gnt  out  1  MEM-stage granted this cycle
- d_rvalid  out  1  MEM-stage read data valid on rdata
- if_req  in  1  fetch request (always read)
- if_addr  in  AW  fetch address (PC)
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch data valid on rdata
- rdata  out  DW  shared read data, equals mem_rdata
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read with mem_en=1

## Operation
- Grant logic is combinational from the current requests and registered state. Exactly one of dbg_gnt/d_gnt/if_gnt is high when any request is high, and none is high when no request is high.
- Priority: dbg > (d vs if) . Between d and if: d wins unless starve_cnt == STARVE_LIMIT, in which case if wins.
- A requester holds its req and its address/data stable until its gnt is seen high. The stall of a requester is req & ~gnt; the pipeline uses it directly.
- Memory port follows the winner: mem_en=1, mem_addr/mem_we/mem_wdata come from the winner, and mem_we=0 for fetch. With no winner: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Response tag: registered rd_owner ∈ {NONE, DBG, D, IF}. It is set on a granted read and set to NONE otherwise, including on granted writes. rvalid outputs decode rd_owner, so at most one rvalid is high.
- Starvation counter starve_cnt is 4 bits:
  - it increments (saturating at STARVE_LIMIT) on a cycle where d_gnt=1 and if_req=1;
  - it clears on if_gnt=1, or when if_req=0;
  - it holds on dbg_gnt cycles with if_req=1.
- Debug grants never advance the counter, and debug may starve both other ports. This is intended for halted-core loading.

## Timing
- Reset (rstn=0 at posedge): rd_owner=NONE and starve_cnt=0, so all rvalid outputs are 0.
  - Grants and mem_* are combinational and must still be 0 while rstn=0.
  - Any read in flight at reset is dropped: no rvalid the cycle after reset.
- Read latency: grant in cycle N gives the matching rvalid and rdata in cycle N+1.
- Writes complete at the granted edge and produce no rvalid.
- Back-to-back grants are allowed every cycle, including a read in N and a write in N+1 to the same address. A read in N returns pre-write data.
- With STARVE_LIMIT=L and continuous d_req and if_req: d is granted L consecutive cycles, if gets cycle L+1, then the pattern repeats (period L+1).
- Simultaneous if_gnt and counter saturation clears the counter the same edge.
- A requester dropping req while not granted is legal: no grant is issued and there are no side effects.

## Test plan
- Reset: drive all three reqs with rstn=0 for 2 cycles → all gnt=0, mem_en=0, rvalid=0. Release → dbg_gnt=1 on the first cycle.
- Single fetch: if_req=1, if_addr=0x10, mem holds 0x7C at 0x10 → if_gnt=1 in cycle N; if_rvalid=1 and rdata=0x7C in N+1; d_rvalid=dbg_rvalid=0.
- Data vs fetch contention with STARVE_LIMIT=4: continuous d_req reads at 0x20 and if_req at 0x00 for 10 cycles → grant sequence d,d,d,d,if,d,d,d,d,if.
- Debug load: dbg writes 0xB2 to 0x05 while if_req=1 → dbg_gnt=1 and if stalled. The next cycle a fetch of 0x05 returns 0xB2, with no dbg_rvalid.
- Read-then-write: d reads 0x30 (holding 0x11) in N, and d writes 0x99 to 0x30 in N+1 → d_rvalid with rdata=0x11 in N+1. A read in N+2 returns 0x99.
- Reset mid-read: fetch granted in N, rstn=0 at edge N+1 → if_rvalid=0 in N+1, and starve_cnt=0 afterward.
